// File: rtl/multiplier_pkg.sv
// Shared types and constants for the multiplier datapath.
//   acc_fsm_t         : product accumulator state encoding
//   PROD_WIDTH_DEF    : product width of the default 8-bit multiplier
//   prod_width()      : product width for a given operand width
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_fsm_t;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PROD_WIDTH_DEF = 2 * DATA_WIDTH_DEF;

    function automatic int unsigned prod_width(input int unsigned dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/saturating_adder.sv
// Unsigned adder that clamps to all ones on carry-out.
//   a, b : addends (ACC_WIDTH)
//   sum  : a+b, or all ones when the true sum does not fit
//   sat  : high when clamping occurred
module saturating_adder #(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    logic [ACC_WIDTH:0] w_raw;

    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b};
        sat   = w_raw[ACC_WIDTH];
        sum   = w_raw[ACC_WIDTH] ? '1 : w_raw[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products into a saturating
// accumulator and hands the result out through a valid/ready handshake.
//   clk_i, rst_i (async, active high), clear_i (sync abort)
//   start_i/length_i             : begin a sum of length_i products (IDLE only)
//   product_i/_valid_i/_ready_o  : product input handshake
//   acc_o/acc_valid_o/acc_ready_i: result output handshake
//   overflow_o                   : sticky saturation flag for the current sum
//   busy_o                       : not idle
module product_accumulator
    import multiplier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    length_i,
    input  logic [2*DATA_WIDTH-1:0] product_i,
    input  logic                    product_valid_i,
    output logic                    product_ready_o,
    output logic [ACC_WIDTH-1:0]    acc_o,
    output logic                    acc_valid_o,
    input  logic                    acc_ready_i,
    output logic                    overflow_o,
    output logic                    busy_o
);

    localparam int unsigned PROD_W = prod_width(DATA_WIDTH);

    if (ACC_WIDTH < PROD_W) begin : g_width_check
        $error("product_accumulator: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end

    acc_fsm_t               r_state;
    logic [LEN_WIDTH-1:0]   r_count;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_overflow;
    logic                   r_prod_ready;
    logic                   r_acc_valid;
    logic                   r_busy;

    logic [ACC_WIDTH-1:0]   w_prod_ext;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic                   w_sat;

    always_comb begin
        w_prod_ext             = '0;
        w_prod_ext[PROD_W-1:0] = product_i;
    end

    saturating_adder #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .a  (r_acc),
        .b  (w_prod_ext),
        .sum(w_sum),
        .sat(w_sat)
    );

    // Handshake outputs are registered alongside the state so they always
    // reflect the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_acc        <= '0;
            r_overflow   <= 1'b0;
            r_prod_ready <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else if (clear_i) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_acc        <= '0;
            r_overflow   <= 1'b0;
            r_prod_ready <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_acc      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (length_i != '0) begin
                            r_count      <= length_i;
                            r_state      <= ACCUM;
                            r_prod_ready <= 1'b1;
                        end else begin
                            r_state     <= DONE;
                            r_acc_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    // ready is always high here, so valid alone marks a transfer
                    if (product_valid_i) begin
                        r_acc   <= w_sum;
                        r_count <= r_count - 1'b1;
                        if (w_sat) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_count == LEN_WIDTH'(1)) begin
                            r_state      <= DONE;
                            r_prod_ready <= 1'b0;
                            r_acc_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready_i) begin
                        r_state     <= IDLE;
                        r_acc_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_prod_ready <= 1'b0;
                    r_acc_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign product_ready_o = r_prod_ready;
    assign acc_o           = r_acc;
    assign acc_valid_o     = r_acc_valid;
    assign overflow_o      = r_overflow;
    assign busy_o          = r_busy;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic [7:0]  length;
    logic [15:0] product;
    logic        pvalid;
    logic        accready;

    logic        pr32, av32, ov32, busy32;
    logic [31:0] acc32;
    logic        pr16, av16, ov16, busy16;
    logic [15:0] acc16;

    always #5 clk = ~clk;

    product_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LEN_WIDTH(8)) dut32 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .length_i(length),
        .product_i(product), .product_valid_i(pvalid), .product_ready_o(pr32),
        .acc_o(acc32), .acc_valid_o(av32), .acc_ready_i(accready),
        .overflow_o(ov32), .busy_o(busy32)
    );

    product_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut16 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .length_i(length),
        .product_i(product), .product_valid_i(pvalid), .product_ready_o(pr16),
        .acc_o(acc16), .acc_valid_o(av16), .acc_ready_i(accready),
        .overflow_o(ov16), .busy_o(busy16)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    exp_t exp32[$];
    exp_t exp16[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: exact sum, clamped to the accumulator range if it exceeds it.
    function automatic void push_expect(input logic [15:0] ps[$]);
        longint unsigned s = 0;
        exp_t e;
        foreach (ps[i]) s += longint'(ps[i]);
        if (s > 64'hFFFF_FFFF) begin e.acc = 32'hFFFF_FFFF; e.ovf = 1'b1; end
        else begin e.acc = s[31:0]; e.ovf = 1'b0; end
        exp32.push_back(e);
        if (s > 64'hFFFF) begin e.acc = 32'h0000_FFFF; e.ovf = 1'b1; end
        else begin e.acc = {16'h0, s[15:0]}; e.ovf = 1'b0; end
        exp16.push_back(e);
    endfunction

    // Monitor: every completed output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && av32 && accready) begin
            if (exp32.size() == 0 || exp16.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got acc %0h with no expected sum queued", acc32);
            end else begin
                exp_t e32, e16;
                e32 = exp32.pop_front();
                e16 = exp16.pop_front();
                chk("acc32", acc32, e32.acc);
                chk("ovf32", 32'(ov32), 32'(e32.ovf));
                chk("valid16", 32'(av16), 32'd1);
                chk("acc16", 32'(acc16), e16.acc);
                chk("ovf16", 32'(ov16), 32'(e16.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start  = 1'b1;
        length = 8'(len);
        tick();
        start  = 1'b0;
    endtask

    // gap >= 0: that many idle cycles between products; gap < 0: random 0..2.
    task automatic feed(input logic [15:0] ps[$], input int gap);
        foreach (ps[i]) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            repeat (g) begin
                pvalid  = 1'b0;
                product = 16'($urandom);
                tick();
                chk("busy_gap", 32'(busy32), 32'd1);
            end
            pvalid  = 1'b1;
            product = ps[i];
            begin
                int w = 0;
                while (!pr32 && w < 20) begin
                    tick();
                    w++;
                end
                if (!pr32) chk("ready_timeout", 32'(pr32), 32'd1);
            end
            tick();
            pvalid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit rand_ready);
        int w = 0;
        while (busy32 && w < 50) begin
            accready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            w++;
        end
        if (busy32) chk("idle_timeout", 32'(busy32), 32'd0);
        accready = 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_acc32"}, acc32, 32'd0);
        chk({name, "_outs32"}, {28'd0, pr32, av32, ov32, busy32}, 32'd0);
        chk({name, "_acc16"}, 32'(acc16), 32'd0);
        chk({name, "_outs16"}, {28'd0, pr16, av16, ov16, busy16}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ps[$];
        logic [31:0] held;

        rst = 1'b1; clear = 1'b0; start = 1'b0; length = '0;
        product = '0; pvalid = 1'b0; accready = 1'b1;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: basic sum, latency
        ps = {16'd6, 16'd10, 16'hFE01};
        push_expect(ps);
        do_start(3);
        chk("t1_busy", 32'(busy32), 32'd1);
        feed(ps, 0);
        chk("t1_latency", 32'(av32), 32'd1);
        wait_idle(0);

        // 2: valid toggling 1-0-1-0
        ps = {};
        repeat (4) ps.push_back(16'($urandom));
        push_expect(ps);
        do_start(4);
        feed(ps, 1);
        chk("t2_latency", 32'(av32), 32'd1);
        wait_idle(0);

        // 3: saturation in the 16-bit instance, cleared by next start
        ps = {16'hFE01, 16'hFE01};
        push_expect(ps);
        do_start(2);
        feed(ps, 0);
        chk("t3_ovf16_done", 32'(ov16), 32'd1);
        chk("t3_acc16_done", 32'(acc16), 32'h0000_FFFF);
        wait_idle(0);
        ps = {16'd7};
        push_expect(ps);
        do_start(1);
        chk("t3_ovf16_cleared", 32'(ov16), 32'd0);
        feed(ps, 0);
        wait_idle(0);

        // 4: backpressure in DONE with ignored start pulses
        accready = 1'b0;
        ps = {};
        repeat (3) ps.push_back(16'($urandom));
        push_expect(ps);
        do_start(3);
        feed(ps, 0);
        held = acc32;
        for (int i = 0; i < 5; i++) begin
            start  = (i % 2 == 0);
            length = 8'd3;
            tick();
            chk("t4_valid_held", 32'(av32), 32'd1);
            chk("t4_acc_held", acc32, held);
            chk("t4_busy_held", 32'(busy32), 32'd1);
        end
        start    = 1'b1;
        accready = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_idle_after_ready", {30'd0, busy32, av32}, 32'd0);
        tick();
        chk("t4_still_idle", 32'(busy32), 32'd0);

        // 5: empty sum
        ps = {};
        push_expect(ps);
        do_start(0);
        chk("t5_valid", 32'(av32), 32'd1);
        chk("t5_no_ready", 32'(pr32), 32'd0);
        chk("t5_acc", acc32, 32'd0);
        wait_idle(0);

        // 6a: async reset mid-sum discards partial result
        ps = {16'($urandom), 16'($urandom)};
        do_start(5);
        feed(ps, 0);
        #2 rst = 1'b1;
        #1 chk_all_zero("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        ps = {16'd7};
        push_expect(ps);
        do_start(1);
        feed(ps, 0);
        chk("t6_acc_after_rst", acc32, 32'd7);
        wait_idle(0);

        // 6b: synchronous clear mid-sum
        ps = {16'($urandom), 16'($urandom)};
        do_start(5);
        feed(ps, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all_zero("t6_clear");
        ps = {16'd7};
        push_expect(ps);
        do_start(1);
        feed(ps, 0);
        chk("t6_acc_after_clear", acc32, 32'd7);
        wait_idle(0);

        // random sums, biased toward large products to exercise saturation
        for (int n = 0; n < 20; n++) begin
            int len;
            len = int'($urandom_range(1, 8));
            ps = {};
            for (int k = 0; k < len; k++)
                ps.push_back($urandom_range(0, 1) ? (16'hF000 | 16'($urandom)) : 16'($urandom));
            push_expect(ps);
            do_start(len);
            feed(ps, -1);
            chk("rand_latency", 32'(av32), 32'd1);
            wait_idle(1);
        end

        tick();
        chk("queue_empty", 32'(exp32.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
